memory_scanner: RTL and testbench

Read-side companion to the 36-cell, 4-bit board-state memory. On a start pulse it walks the memory read address 0..35, samples the memory's combinational read data each cycle, and reassembles the cells into the same packed edge (24 cells, 96 bits) and center (12 cells, 48 bits) words that the memory accepts on its write side. It sits between the board-state memory and the game/display logic that consumes packed snapshots, and drives BUSY so the write side can hold off during a scan.

---
 rtl/memory_scanner.sv | 156 +++++++++++++++
 tb/tb_memory_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_scanner.sv
// -----------------------------------------------------------------------------
// memory_scanner
//
// Read-side companion to the 36-cell board-state memory. A START pulse walks the
// memory read address 0..35 and samples the combinational read data each cycle
// into a shadow register. The completed snapshot is then published as the packed
// edge word (cells 0..23) and center word (cells 24..35) in a single step, so a
// consumer never sees a half-updated snapshot.
//
// Optional feature macro: SCAN_CHANGE_DETECT_EN
//   defined   - CHANGED pulses with DONE when the new snapshot differs from the
//               one currently published (all-zero after reset).
//   undefined - CHANGED is tied low and no comparator exists.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   START           in   scan request, honoured only in IDLE
//   DATA_IN         in   CELL_W  combinational memory read data at ADDR
//   ADDR            out  ADDR_W  memory read address (0 outside a scan)
//   BUSY            out  high while the address walk is in progress
//   DONE            out  one-cycle pulse while the new snapshot is presented
//   CHANGED         out  one-cycle pulse with DONE when the snapshot changed
//   EDGE_DATA_OUT   out  cell 0 in the top nibble, cell 23 in the bottom nibble
//   CENTER_DATA_OUT out  cell 24 in the top nibble, cell 35 in the bottom nibble
// -----------------------------------------------------------------------------
module memory_scanner #(
    parameter int CELL_W       = 4,
    parameter int ADDR_W       = 6,
    parameter int EDGE_CELLS   = 24,
    parameter int CENTER_CELLS = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           START,
    input  logic [CELL_W-1:0]              DATA_IN,
    output logic [ADDR_W-1:0]              ADDR,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           CHANGED,
    output logic [EDGE_CELLS*CELL_W-1:0]   EDGE_DATA_OUT,
    output logic [CENTER_CELLS*CELL_W-1:0] CENTER_DATA_OUT
);

    localparam int                NCELLS    = EDGE_CELLS + CENTER_CELLS;
    localparam int                SNAP_W    = NCELLS * CELL_W;
    localparam int                EDGE_W    = EDGE_CELLS * CELL_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [SNAP_W-1:0]   r_shadow;
    logic [SNAP_W-1:0]   r_snap;
    logic [SNAP_W-1:0]   w_shadow_next;
    logic                w_scan;
    logic                w_last;

    assign w_scan = (r_state == SCAN);
    assign w_last = w_scan && (r_addr == LAST_ADDR);

    // Shadow with the current cell merged in. Cell n lives at the same bit
    // position it occupies in {EDGE_DATA_OUT, CENTER_DATA_OUT}, so publishing
    // the snapshot is a straight copy.
    generate
        for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell
            assign w_shadow_next[SNAP_W-1-gi*CELL_W -: CELL_W] =
                (w_scan && (r_addr == ADDR_W'(gi))) ? DATA_IN
                                                    : r_shadow[SNAP_W-1-gi*CELL_W -: CELL_W];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                BUSY = 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                DONE         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address walk, shadow capture and snapshot publish. The snapshot register
    // is loaded on the edge that captures the last cell, so the new words are
    // already stable throughout the COMMIT cycle in which DONE is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_shadow <= '0;
            r_snap   <= '0;
        end else begin
            if (w_scan) begin
                r_shadow <= w_shadow_next;
                r_addr   <= w_last ? '0 : r_addr + 1'b1;
            end
            if (w_last) begin
                r_snap <= w_shadow_next;
            end
        end
    end

`ifdef SCAN_CHANGE_DETECT_EN
    logic r_changed;

    // Compared against the snapshot still published at that moment, i.e. the
    // previous scan (all-zero after reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_last && (w_shadow_next != r_snap);
        end
    end

    assign CHANGED = r_changed;
`else
    assign CHANGED = 1'b0;
`endif

    assign ADDR            = r_addr;
    assign EDGE_DATA_OUT   = r_snap[SNAP_W-1 -: EDGE_W];
    assign CENTER_DATA_OUT = r_snap[SNAP_W-EDGE_W-1:0];

endmodule

// File: tb/tb_memory_scanner.sv
// -----------------------------------------------------------------------------
// tb_memory_scanner
//
// Directed bench for memory_scanner. A small behavioural memory answers ADDR
// combinationally. Each scan request pushes the expected snapshot (and expected
// CHANGED flag) into a scoreboard queue; a negedge monitor pops and compares
// whenever DONE is seen. Honours SCAN_CHANGE_DETECT_EN for the CHANGED model.
// -----------------------------------------------------------------------------
module tb_memory_scanner;

`ifdef SCAN_CHANGE_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        START;
    logic [3:0]  DATA_IN;
    logic [5:0]  ADDR;
    logic        BUSY;
    logic        DONE;
    logic        CHANGED;
    logic [95:0] EDGE_DATA_OUT;
    logic [47:0] CENTER_DATA_OUT;

    memory_scanner dut (
        .clk             (clk),
        .rst             (rst),
        .START           (START),
        .DATA_IN         (DATA_IN),
        .ADDR            (ADDR),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .CHANGED         (CHANGED),
        .EDGE_DATA_OUT   (EDGE_DATA_OUT),
        .CENTER_DATA_OUT (CENTER_DATA_OUT)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:35];
    assign DATA_IN = (ADDR < 6'd36) ? mem[ADDR] : 4'h0;

    typedef struct {
        logic [143:0] snap;
        logic         ch;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [143:0] model_prev;
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           c0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [143:0] pack_mem();
        logic [143:0] p;
        p = '0;
        for (int i = 0; i < 36; i++) begin
            p[143-4*i -: 4] = mem[i];
        end
        return p;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.snap     = pack_mem();
        e.ch       = DET && (e.snap != model_prev);
        model_prev = e.snap;
        sb.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ADDR > 6'd35) chk("addr_range", ADDR, 35);
            if (CHANGED === 1'b1 && DONE !== 1'b1) chk("changed_without_done", CHANGED, 0);
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn cyc=%0d edge=%h center=%h changed=%b", cyc,
                             EDGE_DATA_OUT, CENTER_DATA_OUT, CHANGED);
                    chk("sb_edge", EDGE_DATA_OUT, mon_e.snap[143:48]);
                    chk("sb_center", CENTER_DATA_OUT, mon_e.snap[47:0]);
                    chk("sb_changed", CHANGED, mon_e.ch);
                end
            end
        end
    end

    // START sampled at the next edge (edge 0); afterwards cycle k = cyc - c0 + 1.
    task automatic pulse_start();
        @(negedge clk);
        START = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        START = 1'b0;
    endtask

    // Follows the scan to DONE; optionally re-pulses START at cycles p1/p2.
    task automatic wait_done(input string tag, input int p1, input int p2);
        int bad   = 0;
        int rel   = 0;
        int found = 0;
        int drel  = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            rel = cyc - c0 + 1;
            if (rel <= 36 && (ADDR !== 6'(rel - 1) || BUSY !== 1'b1)) bad++;
            if (DONE === 1'b1) begin
                found = 1;
                drel  = rel;
            end else begin
                START = (rel == p1 || rel == p2) ? 1'b1 : 1'b0;
            end
        end
        START = 1'b0;
        chk({tag, "_addr_walk"}, bad, 0);
        chk({tag, "_done_cycle"}, drel, 37);
        chk({tag, "_busy_at_done"}, BUSY, 0);
    endtask

    task automatic run_scan(input string tag, input int p1, input int p2);
        push_expected();
        pulse_start();
        wait_done(tag, p1, p2);
    endtask

    initial begin
        int bad;
        int k;
        int dcnt;
        int dq[$];

        rst        = 1'b1;
        START      = 1'b0;
        model_prev = '0;
        for (int i = 0; i < 36; i++) mem[i] = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_addr", ADDR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_changed", CHANGED, 0);
        chk("rst_edge", EDGE_DATA_OUT, 0);
        chk("rst_center", CENTER_DATA_OUT, 0);
        rst = 1'b0;

        // Ramp pattern n mod 16
        for (int i = 0; i < 36; i++) mem[i] = 4'(i % 16);
        run_scan("ramp", 0, 0);
        chk("ramp_edge_const", EDGE_DATA_OUT, 96'h0123456789ABCDEF01234567);
        chk("ramp_center_const", CENTER_DATA_OUT, 48'h89ABCDEF0123);

        // START re-pulsed mid-scan is ignored
        run_scan("ignore", 5, 20);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (DONE === 1'b1) dcnt++;
        end
        chk("ignore_extra_done", dcnt, 0);

        // Reset during cycle 10 of a scan
        pulse_start();
        repeat (10) @(negedge clk);
        chk("mid_busy_before", BUSY, 1);
        chk("mid_addr_before", ADDR, 9);
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", ADDR, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_edge", EDGE_DATA_OUT, 0);
        chk("mid_rst_center", CENTER_DATA_OUT, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_addr_edge", ADDR, 0);
        @(negedge clk);
        rst        = 1'b0;
        model_prev = '0;
        bad        = 0;
        repeat (10) begin
            @(negedge clk);
            if (BUSY !== 1'b0 || ADDR !== 6'd0 || DONE !== 1'b0) bad++;
        end
        chk("mid_idle_hold", bad, 0);
        chk("mid_edge_still_zero", EDGE_DATA_OUT, 0);

        // START held high for 100 cycles
        push_expected();
        push_expected();
        push_expected();
        @(negedge clk);
        START = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            k = cyc - c0 + 1;
            if (k == 100) START = 1'b0;
            if (DONE === 1'b1) dq.push_back(k);
            if (k == 37 || k == 38 || k == 75 || k == 76) chk("held_busy_low", BUSY, 0);
            if (k == 36 || k == 74) chk("held_busy_high", BUSY, 1);
        end
        chk("held_done_count", dq.size(), 3);
        chk("held_done0", (dq.size() > 0) ? dq[0] : 0, 37);
        chk("held_done1", (dq.size() > 1) ? dq[1] : 0, 75);
        chk("held_done2", (dq.size() > 2) ? dq[2] : 0, 113);

        // Change detection sequence
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_prev = '0;
        for (int i = 0; i < 36; i++) mem[i] = 4'h0;
        run_scan("zero", 0, 0);
        chk("zero_changed", CHANGED, 0);
        mem[30] = 4'h7;
        run_scan("cell30", 0, 0);
        chk("cell30_nibble", CENTER_DATA_OUT[23:20], 4'h7);
        chk("cell30_changed", CHANGED, DET);
        run_scan("rescan", 0, 0);
        chk("rescan_changed", CHANGED, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
